mem_request_sequencer: RTL and testbench

MEM_REQUEST_SEQUENCER -- requirements
Module: mem_request_sequencer

---
 rtl/mem_request_sequencer.sv | 167 ++++++++++++++++
 tb/tb_mem_request_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_request_sequencer.sv
// Sequences one control-unit memory instruction to the memory controller:
// capture, single-cycle strobe, wait for completion (with timeout), write-back pulse.
module mem_request_sequencer #(
    parameter int unsigned N_CORES = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    input  logic                    req_store,
    input  logic [N_CORES-1:0]      req_en,
    input  logic [16*N_CORES-1:0]   req_addr,
    input  logic [16*N_CORES-1:0]   req_data,
    output logic                    req_ready,
    output logic                    MRead,
    output logic                    MWrite,
    input  logic                    MReady,
    output logic [N_CORES-1:0]      mc_en,
    output logic [16*N_CORES-1:0]   mc_addr,
    output logic [16*N_CORES-1:0]   mc_data,
    input  logic [16*N_CORES-1:0]   mc_q,
    output logic [N_CORES-1:0]      rd_we,
    output logic [16*N_CORES-1:0]   rd_data,
    output logic                    done,
    output logic                    err
);

    localparam int unsigned DW  = 16 * N_CORES;
    localparam int unsigned CW  = 8;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_WB    = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_store;
    logic [N_CORES-1:0]  r_en;
    logic [DW-1:0]       r_addr;
    logic [DW-1:0]       r_data;
    logic [CW-1:0]       r_cnt;
    logic                r_ready;
    logic                r_mread;
    logic                r_mwrite;
    logic [N_CORES-1:0]  r_rd_we;
    logic [DW-1:0]       r_rd_data;
    logic                r_done;
    logic                r_err;

    state_t              w_next;
    logic                w_capture;
    logic [CW-1:0]       w_cnt;
    logic                w_mread;
    logic                w_mwrite;
    logic [N_CORES-1:0]  w_rd_we;
    logic [DW-1:0]       w_rd_data;
    logic                w_done;
    logic                w_err;

    // Next state and next values of every registered output
    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        w_cnt     = r_cnt;
        w_mread   = 1'b0;
        w_mwrite  = 1'b0;
        w_rd_we   = '0;
        w_rd_data = r_rd_data;
        w_done    = 1'b0;
        w_err     = r_err;
        case (r_state)
            S_IDLE: begin
                if (req_valid && r_ready) begin
                    w_capture = 1'b1;
                    if (|req_en) begin
                        w_next   = S_ISSUE;
                        w_mread  = ~req_store;
                        w_mwrite = req_store;
                    end else begin
                        w_next = S_WB;
                        w_done = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                w_next = S_WAIT;
                w_cnt  = '0;
            end
            S_WAIT: begin
                if (MReady) begin
                    if (!r_store) begin
                        for (int i = 0; i < int'(N_CORES); i++) begin
                            if (r_en[i]) begin
                                w_rd_data[16*i +: 16] = mc_q[16*i +: 16];
                            end
                        end
                        w_rd_we = r_en;
                    end
                    w_done = 1'b1;
                    w_next = S_WB;
                end else if (r_cnt == CNT_LAST) begin
                    // Timeout: complete without write-back and flag it
                    w_err  = 1'b1;
                    w_done = 1'b1;
                    w_next = S_WB;
                end else begin
                    w_cnt = r_cnt + CW'(1);
                end
            end
            S_WB: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_store   <= 1'b0;
            r_en      <= '0;
            r_addr    <= '0;
            r_data    <= '0;
            r_cnt     <= '0;
            r_ready   <= 1'b1;
            r_mread   <= 1'b0;
            r_mwrite  <= 1'b0;
            r_rd_we   <= '0;
            r_rd_data <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_cnt     <= w_cnt;
            r_ready   <= (w_next == S_IDLE);
            r_mread   <= w_mread;
            r_mwrite  <= w_mwrite;
            r_rd_we   <= w_rd_we;
            r_rd_data <= w_rd_data;
            r_done    <= w_done;
            r_err     <= w_err;
            if (w_capture) begin
                r_store <= req_store;
                r_en    <= req_en;
                r_addr  <= req_addr;
                r_data  <= req_data;
            end
        end
    end

    assign req_ready = r_ready;
    assign MRead     = r_mread;
    assign MWrite    = r_mwrite;
    assign mc_en     = r_en;
    assign mc_addr   = r_addr;
    assign mc_data   = r_data;
    assign rd_we     = r_rd_we;
    assign rd_data   = r_rd_data;
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: tb/tb_mem_request_sequencer.sv
// Scoreboard bench for mem_request_sequencer with a cycle-stepped memory model.
module tb_mem_request_sequencer;

    localparam int unsigned NC  = 4;
    localparam int unsigned TO  = 8;
    localparam int unsigned DW  = 16 * NC;

    logic           clk;
    logic           reset;
    logic           req_valid;
    logic           req_store;
    logic [NC-1:0]  req_en;
    logic [DW-1:0]  req_addr;
    logic [DW-1:0]  req_data;
    logic           req_ready;
    logic           MRead;
    logic           MWrite;
    logic           MReady;
    logic [NC-1:0]  mc_en;
    logic [DW-1:0]  mc_addr;
    logic [DW-1:0]  mc_data;
    logic [DW-1:0]  mc_q;
    logic [NC-1:0]  rd_we;
    logic [DW-1:0]  rd_data;
    logic           done;
    logic           err;

    mem_request_sequencer #(.N_CORES(NC), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_store(req_store), .req_en(req_en),
        .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
        .MRead(MRead), .MWrite(MWrite), .MReady(MReady),
        .mc_en(mc_en), .mc_addr(mc_addr), .mc_data(mc_data), .mc_q(mc_q),
        .rd_we(rd_we), .rd_data(rd_data), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit            store;
        logic [NC-1:0] en;
        logic [DW-1:0] addr;
        logic [DW-1:0] data;
        int            lat;
        bit            mute;
        bit            stale;
        bit            b2b;
    } stim_t;

    typedef struct {
        int            done_tick;
        logic [NC-1:0] rd_we;
        logic [DW-1:0] rd_data;
        bit            err;
    } exp_t;

    stim_t          stim_q[$];
    exp_t           exp_q[$];
    logic [15:0]    mem [0:255];
    logic [DW-1:0]  rdbuf;
    logic [DW-1:0]  model_rd;
    bit             model_err;
    bit             force_mr;
    int             cyc;
    int             ready_tick;
    int             stale_tick;
    int             last_done;
    int             checks;
    int             errors;
    stim_t          cur;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic logic [DW-1:0] pack4(input int a0, input int a1, input int a2, input int a3);
        return {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
    endfunction

    // One clock: observe after the edge, update model, then drive next inputs
    task automatic tick();
        bit    acc;
        stim_t s;
        exp_t  e;
        acc = req_valid && req_ready;
        @(posedge clk);
        #1;
        cyc++;
        if (acc) begin
            s = stim_q.pop_front();
            e.rd_we   = '0;
            e.rd_data = model_rd;
            e.err     = model_err;
            if (s.b2b) chk("b2b_accept", 64'(cyc), 64'(last_done + 2));
            chk("ready_busy", 64'(req_ready), 64'd0);
            chk("strobe_rd", 64'(MRead), 64'(!s.store && (|s.en)));
            chk("strobe_wr", 64'(MWrite), 64'(s.store && (|s.en)));
            chk("mc_en", 64'(mc_en), 64'(s.en));
            chk("mc_addr", 64'(mc_addr), 64'(s.addr));
            chk("mc_data", 64'(mc_data), 64'(s.data));
            if (s.en == '0) begin
                e.done_tick = cyc;
            end else if (s.mute) begin
                e.done_tick = cyc + 1 + int'(TO);
                e.err       = 1'b1;
                model_err   = 1'b1;
            end else begin
                e.done_tick = cyc + s.lat + 1;
                ready_tick  = cyc + s.lat;
                if (!s.store) begin
                    e.rd_we = s.en;
                    for (int i = 0; i < int'(NC); i++)
                        if (s.en[i]) e.rd_data[16*i +: 16] = mem[s.addr[16*i +: 8]];
                    model_rd = e.rd_data;
                end
            end
            stale_tick = s.stale ? cyc : -1;
            exp_q.push_back(e);
        end else if (MRead || MWrite) begin
            chk("strobe_stray", 64'({MRead, MWrite}), 64'd0);
        end
        if (MRead && MWrite) chk("strobe_excl", 64'd3, 64'd1);
        if (MWrite) begin
            for (int i = 0; i < int'(NC); i++)
                if (mc_en[i]) mem[mc_addr[16*i +: 8]] = mc_data[16*i +: 16];
        end
        if (MRead) begin
            for (int i = 0; i < int'(NC); i++)
                rdbuf[16*i +: 16] = mc_en[i] ? mem[mc_addr[16*i +: 8]] : 16'(16'hBAD0 + i);
        end
        if (done) begin
            last_done = cyc;
            chk("ready_wb", 64'(req_ready), 64'd0);
            if (exp_q.size() == 0) begin
                chk("done_unexpected", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("done_latency", 64'(cyc), 64'(e.done_tick));
                chk("rd_we", 64'(rd_we), 64'(e.rd_we));
                chk("rd_data", 64'(rd_data), 64'(e.rd_data));
                chk("err", 64'(err), 64'(e.err));
            end
        end else if (exp_q.size() != 0 && cyc > exp_q[0].done_tick) begin
            chk("done_missing", 64'(cyc), 64'(exp_q[0].done_tick));
            void'(exp_q.pop_front());
        end
        MReady = force_mr || (cyc == ready_tick) || (cyc == stale_tick);
        mc_q   = rdbuf;
        if (stim_q.size() != 0) begin
            cur       = stim_q[0];
            req_valid = 1'b1;
            req_store = cur.store;
            req_en    = cur.en;
            req_addr  = cur.addr;
            req_data  = cur.data;
        end else begin
            req_valid = 1'b0;
            req_store = 1'b0;
            req_en    = '0;
            req_addr  = '0;
            req_data  = '0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((stim_q.size() != 0 || exp_q.size() != 0) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) chk("drain_timeout", 64'd1, 64'd0);
        repeat (2) tick();
    endtask

    task automatic push(input bit st, input logic [NC-1:0] en, input logic [DW-1:0] a,
                        input logic [DW-1:0] d, input int lat, input bit mute,
                        input bit stale, input bit b2b);
        stim_t s;
        s.store = st; s.en = en; s.addr = a; s.data = d;
        s.lat = lat; s.mute = mute; s.stale = stale; s.b2b = b2b;
        stim_q.push_back(s);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_ready"}, 64'(req_ready), 64'd1);
        chk({tag, "_strobes"}, 64'({MRead, MWrite}), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_rd_we"}, 64'(rd_we), 64'd0);
        chk({tag, "_err"}, 64'(err), 64'd0);
        chk({tag, "_mc_en"}, 64'(mc_en), 64'd0);
        chk({tag, "_mc_addr"}, 64'(mc_addr), 64'd0);
        chk({tag, "_mc_data"}, 64'(mc_data), 64'd0);
        chk({tag, "_rd_data"}, 64'(rd_data), 64'd0);
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0;
        ready_tick = -1; stale_tick = -1; last_done = -10;
        force_mr = 1'b0; model_rd = '0; model_err = 1'b0; rdbuf = '0;
        for (int i = 0; i < 256; i++) mem[i] = 16'(i * 7 + 3);
        mem[11] = 16'h0014;
        reset = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_en = '0;
        req_addr = '0; req_data = '0; MReady = 1'b0; mc_q = '0;
        tick(); tick();
        check_reset_state("por");
        reset = 1'b0;
        tick();

        // Single-core load
        push(1'b0, 4'b0010, pack4(0, 11, 0, 0), '0, 2, 1'b0, 1'b0, 1'b0);
        drain();

        // Four-core store, then read it back
        push(1'b1, 4'b1111, pack4(20, 21, 22, 23), pack4(9, 20, 55, 24), 1, 1'b0, 1'b0, 1'b0);
        drain();
        chk("mem20", 64'(mem[20]), 64'd9);
        chk("mem21", 64'(mem[21]), 64'd20);
        chk("mem22", 64'(mem[22]), 64'd55);
        chk("mem23", 64'(mem[23]), 64'd24);
        push(1'b0, 4'b1111, pack4(20, 21, 22, 23), '0, 4, 1'b0, 1'b0, 1'b0);
        drain();

        // Empty mask: no strobe, immediate completion
        push(1'b0, 4'b0000, pack4(1, 2, 3, 4), '0, 1, 1'b0, 1'b0, 1'b0);
        drain();

        // MReady high during ISSUE must not complete the request
        push(1'b0, 4'b0100, pack4(0, 0, 60, 0), '0, 3, 1'b0, 1'b1, 1'b0);
        drain();

        // Back-to-back load then store with req_valid held
        push(1'b0, 4'b0101, pack4(5, 0, 7, 0), '0, 1, 1'b0, 1'b0, 1'b0);
        push(1'b1, 4'b1010, pack4(0, 30, 0, 31), pack4(0, 16'h1111, 0, 16'h2222), 2, 1'b0, 1'b0, 1'b1);
        drain();
        chk("mem30", 64'(mem[30]), 64'h1111);
        chk("mem31", 64'(mem[31]), 64'h2222);

        // Timeout, then err must stay set across a normal request
        push(1'b0, 4'b1000, pack4(0, 0, 0, 40), '0, 1, 1'b1, 1'b0, 1'b0);
        drain();
        chk("err_sticky", 64'(err), 64'd1);
        push(1'b0, 4'b0001, pack4(50, 0, 0, 0), '0, 1, 1'b0, 1'b0, 1'b0);
        drain();
        chk("err_sticky2", 64'(err), 64'd1);

        // Reset while in WAIT abandons the request; late MReady ignored
        push(1'b0, 4'b0011, pack4(70, 71, 0, 0), '0, 1, 1'b1, 1'b0, 1'b0);
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        ready_tick = -1; stale_tick = -1;
        model_rd = '0; model_err = 1'b0;
        check_reset_state("wait_rst");
        force_mr = 1'b1;
        repeat (3) tick();
        force_mr = 1'b0;
        repeat (3) tick();
        chk("post_rst_done", 64'(done), 64'd0);
        chk("post_rst_err", 64'(err), 64'd0);

        // Normal operation after reset
        push(1'b0, 4'b1001, pack4(20, 0, 0, 31), '0, 2, 1'b0, 1'b0, 1'b0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
